cnt_decoder: RTL and testbench
==============================

CNT_DECODER -- requirements
Module: cnt_decoder

Interface
REQ-001 Parameter WIDTH, default 8: width of observed count.
REQ-002 Parameter STALL_LIMIT, default 16: consecutive hold samples before stall asserts (range 1..255).
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  clock; all state updates on posedge.
REQ-005 reset  in  1  synchronous active-low reset.
REQ-006 cnt_in  in  WIDTH  count sample from an up/down counter.
REQ-007 cnt_valid  in  1  cnt_in sampled this cycle when high.
REQ-008 enable_out  out  1  one-cycle pulse: legal +1/-1 step decoded.
REQ-009 upndwn_out  out  1  direction of last decoded step; 1 = down, 0 = up.
REQ-010 wrap  out  1  one-cycle pulse: step crossed 2^WIDTH-1 <-> 0.
REQ-011 rst_seen  out  1  one-cycle pulse: counter reset inferred.
REQ-012 err  out  1  one-cycle pulse: illegal jump.
REQ-013 stall  out  1  level: hold run reached STALL_LIMIT.
REQ-014 err_count  out  8  saturating illegal-jump count.
REQ-015 state  out  2  current FSM state encoding.

Function
REQ-016 States SHALL be EMPTY (no previous sample), TRACK, ERR.
REQ-017 In EMPTY, first valid sample SHALL load prev, go to TRACK, assert no pulse.
REQ-018 In TRACK/ERR, delta = (cnt_in - prev) mod 2^WIDTH on each valid sample.
REQ-019 delta = 0: hold; no pulses; hold counter increments, saturating at 255.
REQ-020 delta = 1: up step; enable_out=1, upndwn_out=0; hold counter cleared.
REQ-021 delta = 2^WIDTH-1: down step; enable_out=1, upndwn_out=1; hold counter cleared.
REQ-022 wrap SHALL pulse with up step prev=2^WIDTH-1 -> cnt_in=0, or down step prev=0 -> cnt_in=2^WIDTH-1.
REQ-023 Other delta with cnt_in=0: rst_seen pulse, no err, state TRACK, hold counter cleared.
REQ-024 Any other delta: err pulse, err_count+1 (saturate at 255), state ERR, hold counter cleared.
REQ-025 In ERR, a legal step or hold SHALL return to TRACK; a further illegal jump stays in ERR and counts again.
REQ-026 prev SHALL load cnt_in on every valid sample in every state.
REQ-027 All pulse outputs registered; asserted exactly the cycle after the valid sample, else 0.
REQ-028 cnt_valid low: no state/prev/counter change; pulses deassert; upndwn_out and stall hold.
REQ-029 stall = (hold counter >= STALL_LIMIT); clears on the cycle after a non-hold valid sample.
REQ-030 upndwn_out SHALL change only on a decoded step.

Reset
REQ-031 With reset=0 at posedge: state=EMPTY, prev=0, hold counter=0, err_count=0, all outputs 0.
REQ-032 Reset mid-operation SHALL discard prev; next valid sample re-enters via EMPTY with no pulse.
REQ-033 reset SHALL take priority over cnt_valid in the same cycle.

Structure
REQ-034 Package cnt_dec_pkg SHALL hold the state enum (EMPTY=0, TRACK=1, ERR=2) and step-class enum (HOLD, UP, DOWN, ZERO, ILLEGAL).
REQ-035 Sub-module cnt_step_classifier (combinational: prev, cnt_in -> step class, wrap flag) SHALL be instantiated once.

Verification
REQ-036 Reset, then valid 5,6,7 -> no pulse on 5; enable_out=1, upndwn_out=0 after 6 and 7.
REQ-037 Valid 1,0,255,254 -> three down steps, upndwn_out=1; wrap pulse only on 0->255.
REQ-038 Valid 10,40,41 -> err after 40, err_count=1, state ERR; after 41 enable_out=1, state TRACK.
REQ-039 Valid 77,0 -> rst_seen=1, err=0, err_count unchanged.
REQ-040 STALL_LIMIT=16, valid 3 then 16x 3 -> stall=1 after 16th hold; next 4 -> enable_out=1, stall=0.
REQ-041 Mid-stream reset=0 one cycle, then valid 200 -> no pulses, state EMPTY->TRACK, err_count=0.

Source files
------------

// File: rtl/cnt_dec_pkg.sv
// Shared types for the up/down count decoder.
//   dec_state_e  : decoder FSM state (EMPTY / TRACK / ERR), exported on the state port.
//   step_class_e : classification of one sample against the previous sample.
package cnt_dec_pkg;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StTrack = 2'd1,
    StErr   = 2'd2
  } dec_state_e;

  typedef enum logic [2:0] {
    StepHold    = 3'd0,
    StepUp      = 3'd1,
    StepDown    = 3'd2,
    StepZero    = 3'd3,
    StepIllegal = 3'd4
  } step_class_e;

  // Saturation ceiling shared by the hold counter and the error counter.
  localparam logic [7:0] SatMax = 8'hFF;

endpackage

// File: rtl/cnt_step_classifier.sv
// Combinational step classifier.
//   i_prev : previous count sample
//   i_cnt  : current count sample
//   o_step : step class (step_class_e encoding)
//   o_wrap : step crosses the 2^WIDTH-1 <-> 0 boundary
module cnt_step_classifier
  import cnt_dec_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_prev,
  input  logic [WIDTH-1:0] i_cnt,
  output logic [2:0]       o_step,
  output logic             o_wrap
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);
  localparam logic [WIDTH-1:0] Max = '1;

  logic [WIDTH-1:0] w_delta;

  // Modular difference; the subtraction wraps naturally at WIDTH bits.
  assign w_delta = i_cnt - i_prev;

  always_comb begin
    o_step = StepIllegal;
    o_wrap = 1'b0;
    // Up is tested before down so that WIDTH=1 (where 1 == 2^WIDTH-1) decodes as up.
    if (w_delta == '0) begin
      o_step = StepHold;
    end else if (w_delta == One) begin
      o_step = StepUp;
      o_wrap = (i_prev == Max);
    end else if (w_delta == Max) begin
      o_step = StepDown;
      o_wrap = (i_prev == '0);
    end else if (i_cnt == '0) begin
      o_step = StepZero;
    end
  end

endmodule

// File: rtl/cnt_decoder.sv
// Observes samples of an up/down counter and decodes legal steps, wraps,
// inferred counter resets, illegal jumps and stalls.
//   clk        : clock
//   reset      : synchronous active-low reset
//   cnt_in     : count sample, qualified by cnt_valid
//   enable_out : pulse, legal +1/-1 step decoded
//   upndwn_out : direction of last decoded step (1 = down)
//   wrap       : pulse, step crossed 2^WIDTH-1 <-> 0
//   rst_seen   : pulse, jump to zero interpreted as counter reset
//   err        : pulse, illegal jump
//   stall      : level, hold run length >= STALL_LIMIT
//   err_count  : saturating illegal-jump count
//   state      : FSM state encoding
module cnt_decoder
  import cnt_dec_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned STALL_LIMIT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             cnt_valid,
  output logic             enable_out,
  output logic             upndwn_out,
  output logic             wrap,
  output logic             rst_seen,
  output logic             err,
  output logic             stall,
  output logic [7:0]       err_count,
  output logic [1:0]       state
);

  localparam logic [7:0] StallLimit = 8'(STALL_LIMIT);

  dec_state_e       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_prev, w_prev_nxt;
  logic [7:0]       r_hold_cnt, w_hold_nxt;
  logic [7:0]       r_err_cnt, w_err_cnt_nxt;
  logic             r_enable, w_enable_nxt;
  logic             r_upndwn, w_upndwn_nxt;
  logic             r_wrap, w_wrap_nxt;
  logic             r_rst_seen, w_rst_seen_nxt;
  logic             r_err, w_err_nxt;

  logic [2:0]       w_step_raw;
  step_class_e      w_step;
  logic             w_step_wrap;

  cnt_step_classifier #(
    .WIDTH (WIDTH)
  ) u_classifier (
    .i_prev (r_prev),
    .i_cnt  (cnt_in),
    .o_step (w_step_raw),
    .o_wrap (w_step_wrap)
  );

  assign w_step = step_class_e'(w_step_raw);

  always_comb begin
    w_state_nxt    = r_state;
    w_prev_nxt     = r_prev;
    w_hold_nxt     = r_hold_cnt;
    w_err_cnt_nxt  = r_err_cnt;
    w_enable_nxt   = 1'b0;
    w_upndwn_nxt   = r_upndwn;
    w_wrap_nxt     = 1'b0;
    w_rst_seen_nxt = 1'b0;
    w_err_nxt      = 1'b0;

    if (cnt_valid) begin
      w_prev_nxt = cnt_in;
      if (r_state == StEmpty) begin
        // First sample only establishes the reference; nothing to compare against.
        w_state_nxt = StTrack;
        w_hold_nxt  = '0;
      end else begin
        case (w_step)
          StepHold: begin
            w_state_nxt = StTrack;
            if (r_hold_cnt != SatMax) w_hold_nxt = r_hold_cnt + 8'd1;
          end
          StepUp: begin
            w_state_nxt  = StTrack;
            w_enable_nxt = 1'b1;
            w_upndwn_nxt = 1'b0;
            w_wrap_nxt   = w_step_wrap;
            w_hold_nxt   = '0;
          end
          StepDown: begin
            w_state_nxt  = StTrack;
            w_enable_nxt = 1'b1;
            w_upndwn_nxt = 1'b1;
            w_wrap_nxt   = w_step_wrap;
            w_hold_nxt   = '0;
          end
          StepZero: begin
            w_state_nxt    = StTrack;
            w_rst_seen_nxt = 1'b1;
            w_hold_nxt     = '0;
          end
          default: begin
            w_state_nxt = StErr;
            w_err_nxt   = 1'b1;
            w_hold_nxt  = '0;
            if (r_err_cnt != SatMax) w_err_cnt_nxt = r_err_cnt + 8'd1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= StEmpty;
      r_prev     <= '0;
      r_hold_cnt <= '0;
      r_err_cnt  <= '0;
      r_enable   <= 1'b0;
      r_upndwn   <= 1'b0;
      r_wrap     <= 1'b0;
      r_rst_seen <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_prev     <= w_prev_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_err_cnt  <= w_err_cnt_nxt;
      r_enable   <= w_enable_nxt;
      r_upndwn   <= w_upndwn_nxt;
      r_wrap     <= w_wrap_nxt;
      r_rst_seen <= w_rst_seen_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign enable_out = r_enable;
  assign upndwn_out = r_upndwn;
  assign wrap       = r_wrap;
  assign rst_seen   = r_rst_seen;
  assign err        = r_err;
  // Hold counter is registered, so stall follows the sample by one cycle like the pulses.
  assign stall      = (r_hold_cnt >= StallLimit);
  assign err_count  = r_err_cnt;
  assign state      = r_state;

endmodule

// File: tb/tb_cnt_decoder.sv
// Directed self-checking bench for cnt_decoder (WIDTH=8, STALL_LIMIT=16).
// Output vector compared per sample: {enable_out, upndwn_out, wrap, rst_seen, err, stall, state}.
module tb_cnt_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cnt_in;
  logic       cnt_valid;
  logic       enable_out, upndwn_out, wrap, rst_seen, err, stall;
  logic [7:0] err_count;
  logic [1:0] state;

  int n_checks = 0;
  int n_errors = 0;

  cnt_decoder #(
    .WIDTH       (8),
    .STALL_LIMIT (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cnt_in     (cnt_in),
    .cnt_valid  (cnt_valid),
    .enable_out (enable_out),
    .upndwn_out (upndwn_out),
    .wrap       (wrap),
    .rst_seen   (rst_seen),
    .err        (err),
    .stall      (stall),
    .err_count  (err_count),
    .state      (state)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] obs();
    return {enable_out, upndwn_out, wrap, rst_seen, err, stall, state};
  endfunction

  // Apply inputs at negedge, return 1 time unit after the following posedge.
  task automatic drive(input logic rst_n, input logic vld, input logic [7:0] v);
    @(negedge clk);
    reset     = rst_n;
    cnt_valid = vld;
    cnt_in    = v;
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [7:0] v);
    drive(1'b1, 1'b1, v);
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 8'd0);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_reset();
    // Reset asserted together with a valid sample: reset wins.
    drive(1'b0, 1'b1, 8'd5);
    if (obs() !== 8'h00) begin
      $display("FAIL reset_outs got=%h exp=%h", obs(), 8'h00); n_errors++;
    end
    n_checks++;
    if (err_count !== 8'd0) begin
      $display("FAIL reset_errcnt got=%0d exp=0", err_count); n_errors++;
    end
    n_checks++;
  endtask

  task automatic test_up();
    logic [7:0] vals [4] = '{8'd5, 8'd6, 8'd7, 8'd7};
    logic [7:0] exps [4] = '{8'h01, 8'h81, 8'h81, 8'h01};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sample(vals[i]);
      if (obs() !== exps[i]) begin
        $display("FAIL up_%0d got=%h exp=%h", i, obs(), exps[i]); n_errors++;
      end
      n_checks++;
    end
  endtask

  task automatic test_down();
    logic [7:0] vals [4] = '{8'd1, 8'd0, 8'd255, 8'd254};
    logic [7:0] exps [4] = '{8'h01, 8'hC1, 8'hE1, 8'hC1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sample(vals[i]);
      if (obs() !== exps[i]) begin
        $display("FAIL down_%0d got=%h exp=%h", i, obs(), exps[i]); n_errors++;
      end
      n_checks++;
    end
    // Idle: pulses drop, direction holds.
    idle();
    if (obs() !== 8'h41) begin
      $display("FAIL down_idle got=%h exp=%h", obs(), 8'h41); n_errors++;
    end
    n_checks++;
  endtask

  task automatic test_wrap_up();
    logic [7:0] vals [4] = '{8'd254, 8'd255, 8'd0, 8'd1};
    logic [7:0] exps [4] = '{8'h01, 8'h81, 8'hA1, 8'h81};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sample(vals[i]);
      if (obs() !== exps[i]) begin
        $display("FAIL wrapup_%0d got=%h exp=%h", i, obs(), exps[i]); n_errors++;
      end
      n_checks++;
    end
  endtask

  task automatic test_err();
    logic [7:0] vals [7] = '{8'd10, 8'd40, 8'd41, 8'd100, 8'd200, 8'd200, 8'd201};
    logic [7:0] exps [7] = '{8'h01, 8'h0A, 8'h81, 8'h0A, 8'h0A, 8'h01, 8'h81};
    logic [7:0] ecnt [7] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd3, 8'd3};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      sample(vals[i]);
      if (obs() !== exps[i]) begin
        $display("FAIL err_%0d got=%h exp=%h", i, obs(), exps[i]); n_errors++;
      end
      n_checks++;
      if (err_count !== ecnt[i]) begin
        $display("FAIL errcnt_%0d got=%0d exp=%0d", i, err_count, ecnt[i]); n_errors++;
      end
      n_checks++;
    end
  endtask

  task automatic test_zero();
    logic [7:0] vals [5] = '{8'd77, 8'd0, 8'd50, 8'd0, 8'd255};
    logic [7:0] exps [5] = '{8'h01, 8'h11, 8'h0A, 8'h11, 8'hE1};
    logic [7:0] ecnt [5] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      sample(vals[i]);
      if (obs() !== exps[i]) begin
        $display("FAIL zero_%0d got=%h exp=%h", i, obs(), exps[i]); n_errors++;
      end
      n_checks++;
      if (err_count !== ecnt[i]) begin
        $display("FAIL zerocnt_%0d got=%0d exp=%0d", i, err_count, ecnt[i]); n_errors++;
      end
      n_checks++;
    end
  endtask

  task automatic test_stall();
    logic [7:0] exp;
    do_reset();
    sample(8'd3);
    for (int i = 1; i <= 16; i++) begin
      sample(8'd3);
      exp = (i < 16) ? 8'h01 : 8'h05;
      if (obs() !== exp) begin
        $display("FAIL stall_hold%0d got=%h exp=%h", i, obs(), exp); n_errors++;
      end
      n_checks++;
    end
    idle();
    if (obs() !== 8'h05) begin
      $display("FAIL stall_idle got=%h exp=%h", obs(), 8'h05); n_errors++;
    end
    n_checks++;
    sample(8'd4);
    if (obs() !== 8'h81) begin
      $display("FAIL stall_clear got=%h exp=%h", obs(), 8'h81); n_errors++;
    end
    n_checks++;
    // Long hold run: counter must saturate, not wrap back below the limit.
    for (int i = 0; i < 300; i++) sample(8'd4);
    if (obs() !== 8'h05) begin
      $display("FAIL stall_sat got=%h exp=%h", obs(), 8'h05); n_errors++;
    end
    n_checks++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    sample(8'd10);
    sample(8'd40);
    if (err_count !== 8'd1) begin
      $display("FAIL midrst_pre got=%0d exp=1", err_count); n_errors++;
    end
    n_checks++;
    drive(1'b0, 1'b1, 8'd41);
    if (obs() !== 8'h00) begin
      $display("FAIL midrst_outs got=%h exp=%h", obs(), 8'h00); n_errors++;
    end
    n_checks++;
    if (err_count !== 8'd0) begin
      $display("FAIL midrst_cnt got=%0d exp=0", err_count); n_errors++;
    end
    n_checks++;
    sample(8'd200);
    if (obs() !== 8'h01) begin
      $display("FAIL midrst_first got=%h exp=%h", obs(), 8'h01); n_errors++;
    end
    n_checks++;
    sample(8'd201);
    if (obs() !== 8'h81) begin
      $display("FAIL midrst_step got=%h exp=%h", obs(), 8'h81); n_errors++;
    end
    n_checks++;
  endtask

  task automatic test_err_sat();
    do_reset();
    sample(8'd0);
    // 0 -> 100 -> 200 -> 100 ... every step is an illegal jump.
    for (int i = 0; i < 255; i++) sample((i % 2 == 0) ? 8'd100 : 8'd200);
    if (err_count !== 8'd255) begin
      $display("FAIL errsat_255 got=%0d exp=255", err_count); n_errors++;
    end
    n_checks++;
    sample(8'd50);
    if (err_count !== 8'd255) begin
      $display("FAIL errsat_hold got=%0d exp=255", err_count); n_errors++;
    end
    n_checks++;
    if (obs() !== 8'h0A) begin
      $display("FAIL errsat_pulse got=%h exp=%h", obs(), 8'h0A); n_errors++;
    end
    n_checks++;
  endtask

  initial begin
    reset     = 1'b0;
    cnt_valid = 1'b0;
    cnt_in    = 8'd0;
    test_reset();
    test_up();
    test_down();
    test_wrap_up();
    test_err();
    test_zero();
    test_stall();
    test_mid_reset();
    test_err_sat();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
